i2c_frame_serializer: RTL and testbench
=======================================

// Module: i2c_frame_serializer
// PURPOSE
//  Transmit side of the serial FIFO link. Accepts parallel {7-bit address, 8-bit data} words
//  over a valid/ready handshake and buffers them in a small queue. Emits each word as one frame:
//  a one-cycle wr_en start pulse, then 15 bits on addr_data, MSB first.
//  Sits between the I2C command source and the i2c FIFO's write port.
// PARAMETERS
//  ADDR_W      7  address field width
//  DATA_W      8  data field width; FRAME_W = ADDR_W+DATA_W = 15 (derived, not overridable)
//  QDEPTH      2  input queue entries; power of two, >= 2
//  GAP_CYCLES  2  idle cycles forced after each frame; 0 is legal
// PORTS
//  clk         in   1        clock; all logic on posedge
//  rst         in   1        synchronous reset, active-low (0 = reset)
//  in_valid    in   1        word offered
//  in_ready    out  1        queue can accept; transfer on in_valid && in_ready at posedge
//  in_addr     in   ADDR_W   address field, sent first
//  in_data     in   DATA_W   data field, sent after the address
//  wr_en       out  1        frame start pulse, exactly one cycle per frame
//  addr_data   out  1        serial bit; 0 whenever not shifting
//  frame_done  out  1        one-cycle pulse after the last bit of each frame
//  busy        out  1        queue non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (rst=0 at posedge): in_ready=0, wr_en=0, addr_data=0, frame_done=0, busy=0.
//   FSM goes to IDLE, queue pointers and counters clear, queued words are discarded.
//   in_ready=1 from the first cycle after rst returns to 1.
//  Reset mid-frame aborts the frame: outputs are 0 after that edge, and no partial frame resumes.
//  All outputs are registered.
//  Queue: circular buffer of {addr,data}. in_ready = !full.
//   There is no pass-through: a push while full is refused even if a pop happens the same cycle.
//   A push to an empty queue is visible to the FSM on the next cycle.
//   A push and a pop in the same cycle are both honoured; occupancy is unchanged.
//   Pointers wrap modulo QDEPTH.
//  Frame word: shreg = {in_addr, in_data}. bit 14 = in_addr[6]; bit 0 = in_data[0].
//  FSM states: IDLE, START, SHIFT, GAP.
//   IDLE:  if the queue is non-empty, pop into shreg, set wr_en<=1, go to START; else stay.
//   START: wr_en is high this cycle. Set cnt<=FRAME_W-1 and addr_data<=shreg[14], go to SHIFT.
//   SHIFT: addr_data shows shreg[cnt]. At the edge: if cnt==0, set addr_data<=0 and
//          frame_done<=1, then go to GAP (or IDLE if GAP_CYCLES==0); else cnt-1.
//   GAP:   hold GAP_CYCLES cycles with all outputs 0 (frame_done high only in the first
//          cycle), then go to IDLE.
//  Timing from the accepting edge E0 with the FSM idle:
//   wr_en is high during E1..E2.
//   Bit 14 is on addr_data during E2..E3, and bit 0 during E16..E17.
//   frame_done is high during E17..E18.
//  Back-to-back frames have a wr_en-to-wr_en period of FRAME_W+2+GAP_CYCLES (19 by default).
//  Words are sent strictly in acceptance order. No word is lost or duplicated.
//  busy goes to 1 the cycle after the first accept and drops to 0 once IDLE is reached
//   with the queue empty.
// STRUCTURE
//  Package i2c_pkg holds ADDR_W, DATA_W, FRAME_W and the FSM state enum
//   (2-bit: IDLE=0, START=1, SHIFT=2, GAP=3).
//  Sub-module i2c_frame_queue is the QDEPTH-entry circular buffer:
//   push/pop/full/empty/head, synchronous active-low reset.
//  The top level holds the FSM, shreg, the bit counter and the gap counter.
// TESTING
//  1. Hold rst=0 for 3 cycles -> wr_en=addr_data=frame_done=busy=0 and in_ready=0;
//     after release, in_ready=1 and nothing is emitted.
//  2. Push addr=7'h50, data=8'hA5 -> wr_en during E1..E2; addr_data bits, MSB first,
//     1010000_10100101 during E2..E17; frame_done during E17..E18; busy back to 0 at E19.
//  3. in_valid held high with 4 distinct words (QDEPTH=2) -> in_ready drops while the queue
//     is full; all 4 frames emitted in order, wr_en pulses exactly 19 cycles apart.
//  4. rst=0 during the 8th bit of frame 1 with one word queued -> all outputs 0 next cycle;
//     no further wr_en after release until a new push.
//  5. GAP_CYCLES=0 with 2 queued words -> wr_en pulses 17 cycles apart; frame_done pulses
//     coincide with the IDLE cycle.
//  6. Push 7'h7F/8'hFF then 7'h00/8'h00 -> first frame is 15 ones, second is 15 zeros,
//     each preceded by exactly one wr_en cycle; addr_data=0 outside SHIFT.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared widths and FSM encoding for the I2C frame serializer.
package i2c_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/i2c_frame_queue.sv
// Circular buffer of frame words; a push while full is dropped, pops from empty are ignored.
module i2c_frame_queue
    import i2c_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2c_frame_serializer.sv
// Serializes queued {addr,data} words into wr_en-led, MSB-first 15-bit frames.
module i2c_frame_serializer
    import i2c_pkg::*;
#(
    parameter int QDEPTH     = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic              addr_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int CW = $clog2(FRAME_W);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int LW = $clog2(QDEPTH) + 1;
    localparam logic [LW-1:0] QDEPTH_L = LW'(QDEPTH);
    localparam logic [GW-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    state_t             state, state_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [GW-1:0]      gcnt, gcnt_n;
    logic               wr_en_n, addr_data_n, frame_done_n, busy_n, in_ready_n;

    logic               q_push, q_pop, q_full, q_empty;
    logic [FRAME_W-1:0] q_head;
    logic [LW-1:0]      q_level, level_n;

    assign q_push = in_valid && in_ready;
    assign q_pop  = (state == IDLE) && !q_empty;

    i2c_frame_queue #(
        .WIDTH (FRAME_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({in_addr, in_data}),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .level (q_level)
    );

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        gcnt_n       = gcnt;
        wr_en_n      = 1'b0;
        addr_data_n  = 1'b0;
        frame_done_n = 1'b0;

        case (state)
            IDLE: begin
                if (!q_empty) begin
                    shreg_n = q_head;
                    wr_en_n = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                cnt_n       = CW'(FRAME_W - 1);
                addr_data_n = shreg[FRAME_W-1];
                state_n     = SHIFT;
            end
            SHIFT: begin
                if (cnt == '0) begin
                    frame_done_n = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        gcnt_n  = GAP_INIT;
                        state_n = GAP;
                    end
                end else begin
                    cnt_n       = cnt - CW'(1);
                    addr_data_n = shreg[cnt_n];
                end
            end
            GAP: begin
                if (gcnt == '0) state_n = IDLE;
                else            gcnt_n  = gcnt - GW'(1);
            end
            default: state_n = IDLE;
        endcase

        // Post-edge occupancy keeps in_ready and busy registered yet current.
        level_n = q_level;
        if (q_push && !q_full) level_n = level_n + LW'(1);
        if (q_pop)             level_n = level_n - LW'(1);
        in_ready_n = (level_n != QDEPTH_L);
        busy_n     = (state_n != IDLE) || (level_n != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            wr_en      <= 1'b0;
            addr_data  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            gcnt       <= gcnt_n;
            wr_en      <= wr_en_n;
            addr_data  <= addr_data_n;
            frame_done <= frame_done_n;
            busy       <= busy_n;
            in_ready   <= in_ready_n;
        end
    end

endmodule

// File: tb/tb_i2c_frame_serializer.sv
// Self-checking bench: constant tables, directed frame sequences and a per-cycle timeline model.
module tb_i2c_frame_serializer;

    localparam int QD  = 2;
    localparam int GAP = 2;
    localparam int FW  = 15;
    localparam int L   = FW + 2 + GAP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_ready, wr_en, addr_data, frame_done, busy;
    logic [6:0] in_addr = '0;
    logic [7:0] in_data = '0;
    logic v0 = 1'b0, r0, wr0, ad0, fd0, b0;
    logic [6:0] a0 = '0;
    logic [7:0] d0 = '0;

    int checks = 0;
    int errors = 0;

    i2c_frame_serializer #(.QDEPTH(QD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wr_en(wr_en),
        .addr_data(addr_data), .frame_done(frame_done), .busy(busy)
    );

    i2c_frame_serializer #(.QDEPTH(2), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0),
        .in_addr(a0), .in_data(d0), .wr_en(wr0),
        .addr_data(ad0), .frame_done(fd0), .busy(b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Timeline model: a frame occupies L cycles after its pop; the last one is the idle cycle.
    logic [14:0] mq[$];
    logic [14:0] m_cur;
    bit m_act, m_push, m_ready, m_wr, m_ad, m_fd, m_busy;
    int m_phase;

    always @(posedge clk) begin
        m_push = in_valid && m_ready;
        if (!rst) begin
            mq.delete();
            m_act = 0; m_phase = 0; m_ready = 0;
        end else begin
            if ((!m_act || m_phase == L - 1) && mq.size() > 0) begin
                m_cur = mq.pop_front(); m_act = 1; m_phase = 0;
            end else if (m_act && m_phase == L - 1) begin
                m_act = 0;
            end else if (m_act) begin
                m_phase++;
            end
            if (m_push) mq.push_back({in_addr, in_data});
            m_ready = (mq.size() < QD);
        end
        m_wr   = m_act && m_phase == 0;
        m_ad   = (m_act && m_phase >= 1 && m_phase <= FW) ? m_cur[FW - m_phase] : 1'b0;
        m_fd   = m_act && m_phase == FW + 1;
        m_busy = (m_act && m_phase < L - 1) || mq.size() > 0;
    end

    always @(negedge clk) begin
        chk("m_wr_en", wr_en, m_wr);
        chk("m_addr_data", addr_data, m_ad);
        chk("m_frame_done", frame_done, m_fd);
        chk("m_busy", busy, m_busy);
        chk("m_in_ready", in_ready, m_ready);
    end

    // Stream capture used by the directed multi-frame sequences.
    logic [6:0] wa [8];
    logic [7:0] wd [8];
    logic h_wr [256], h_ad [256], h_fd [256], h_rdy [256];
    int hlen;

    task automatic stream(input bit sel, input int n, input int cycles);
        int nw = 0;
        bit acc;
        for (int t = 0; t < cycles; t++) begin
            if (sel) begin
                v0 = (nw < n);
                if (nw < n) begin a0 = wa[nw]; d0 = wd[nw]; end
                acc = v0 && r0;
            end else begin
                in_valid = (nw < n);
                if (nw < n) begin in_addr = wa[nw]; in_data = wd[nw]; end
                acc = in_valid && in_ready;
            end
            @(negedge clk);
            if (acc) nw++;
            h_wr[t]  = sel ? wr0 : wr_en;
            h_ad[t]  = sel ? ad0 : addr_data;
            h_fd[t]  = sel ? fd0 : frame_done;
            h_rdy[t] = sel ? r0  : in_ready;
        end
        v0 = 1'b0;
        in_valid = 1'b0;
        hlen = cycles;
        chk("accepted_words", nw, n);
    endtask

    task automatic analyze(input string tag, input int n, input int period);
        int wt[$];
        int nfd = 0, viol = 0;
        bit in_win;
        for (int t = 0; t < hlen; t++) begin
            if (h_wr[t] === 1'b1) wt.push_back(t);
            if (h_fd[t] === 1'b1) nfd++;
        end
        chk({tag, "_frame_count"}, wt.size(), n);
        chk({tag, "_done_count"}, nfd, n);
        for (int k = 0; k < wt.size() && k < n; k++) begin
            logic [14:0] f = '0;
            for (int i = 0; i < FW; i++)
                if (wt[k] + 1 + i < hlen) f[FW - 1 - i] = h_ad[wt[k] + 1 + i];
            chk({tag, "_frame_bits"}, f, {wa[k], wd[k]});
            chk({tag, "_done_pos"}, (wt[k] + 16 < hlen) ? h_fd[wt[k] + 16] : 1'b0, 1);
            if (k > 0) chk({tag, "_wr_period"}, wt[k] - wt[k-1], period);
        end
        for (int t = 0; t < hlen; t++) begin
            in_win = 0;
            foreach (wt[k]) if (t > wt[k] && t <= wt[k] + FW) in_win = 1;
            if (!in_win && h_ad[t] === 1'b1) viol++;
        end
        chk({tag, "_ad_outside_shift"}, viol, 0);
    endtask

    typedef struct {
        logic       valid;
        logic [6:0] addr;
        logic [7:0] data;
        logic       wr, ad, fd, bsy, rdy;
    } vec_t;

    localparam int TN = 21;
    vec_t tbl [TN];

    initial begin
        logic [14:0] w;
        int cnt_wr;
        bit low_seen;

        w = {7'h50, 8'hA5};
        for (int j = 0; j < TN; j++) begin
            tbl[j].valid = (j == 0);
            tbl[j].addr  = 7'h50;
            tbl[j].data  = 8'hA5;
            tbl[j].wr    = (j == 1);
            tbl[j].ad    = (j >= 2 && j <= 16) ? w[16 - j] : 1'b0;
            tbl[j].fd    = (j == 17);
            tbl[j].bsy   = (j <= 18);
            tbl[j].rdy   = 1'b1;
        end

        // Reset hold and release.
        repeat (3) begin
            @(negedge clk);
            chk("rst_wr_en", wr_en, 0);
            chk("rst_addr_data", addr_data, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("release_quiet", {wr_en, addr_data, frame_done, busy}, 0);
        end

        // Single frame against the constant timing table.
        for (int j = 0; j < TN; j++) begin
            in_valid = tbl[j].valid; in_addr = tbl[j].addr; in_data = tbl[j].data;
            @(negedge clk);
            chk($sformatf("tbl_wr_en[%0d]", j), wr_en, tbl[j].wr);
            chk($sformatf("tbl_addr_data[%0d]", j), addr_data, tbl[j].ad);
            chk($sformatf("tbl_frame_done[%0d]", j), frame_done, tbl[j].fd);
            chk($sformatf("tbl_busy[%0d]", j), busy, tbl[j].bsy);
            chk($sformatf("tbl_in_ready[%0d]", j), in_ready, tbl[j].rdy);
        end

        // Four words with in_valid held: backpressure, order, 19-cycle period.
        wa[0] = 7'h11; wd[0] = 8'h3C;
        wa[1] = 7'h6A; wd[1] = 8'hC1;
        wa[2] = 7'h05; wd[2] = 8'h7E;
        wa[3] = 7'h48; wd[3] = 8'h92;
        stream(0, 4, 85);
        analyze("b2b", 4, 19);
        low_seen = 0;
        for (int t = 0; t < hlen; t++) if (h_rdy[t] === 1'b0) low_seen = 1;
        chk("b2b_ready_dropped", low_seen, 1);
        chk("b2b_idle_busy", busy, 0);

        // All-ones then all-zeros frames.
        wa[0] = 7'h7F; wd[0] = 8'hFF;
        wa[1] = 7'h00; wd[1] = 8'h00;
        stream(0, 2, 45);
        analyze("ones_zeros", 2, 19);

        // Reset during the 8th bit of the first frame with a second word queued.
        wa[0] = 7'h2B; wd[0] = 8'h5D;
        wa[1] = 7'h33; wd[1] = 8'hE4;
        stream(0, 2, 10);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_addr_data", addr_data, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b1;
        cnt_wr = 0;
        repeat (40) begin
            @(negedge clk);
            if (wr_en === 1'b1) cnt_wr++;
        end
        chk("abort_no_resume", cnt_wr, 0);

        // Zero-gap instance: 17-cycle period, frame_done in the idle cycle.
        wa[0] = 7'h1D; wd[0] = 8'hA0;
        wa[1] = 7'h62; wd[1] = 8'h0F;
        stream(1, 2, 45);
        analyze("gap0", 2, 17);
        chk("gap0_idle_busy", b0, 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 249) != 0);
            in_valid = ($urandom_range(0, 2) == 0);
            in_addr  = 7'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("drain_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
